// File: rtl/bsg_cgol_pkg.sv
// Shared definitions for the Life-like cellular automaton row.
//   - Standard rule masks in B/S notation. Bit n of a mask covers n live neighbours.
//   - A neighbour index wrap helper used at elaboration time.
package bsg_cgol_pkg;

  // Conway: B3/S23
  localparam logic [8:0] bsg_cgol_birth_conway   = 9'b0_0000_1000;
  localparam logic [8:0] bsg_cgol_survive_conway = 9'b0_0000_1100;

  // HighLife: B36/S23 (survival mask is the same as Conway)
  localparam logic [8:0] bsg_cgol_birth_highlife = 9'b0_0100_1000;

  // Maps any index (including -1 and width) onto 0..width-1 toroidally.
  function automatic int bsg_cgol_wrap_idx(input int idx, input int width);
    return ((idx % width) + width) % width;
  endfunction

endpackage

// File: rtl/bsg_cgol_rule_cell.sv
// Combinational next-state logic for one Life-like cell.
//   nbr_i          : the eight neighbour states (order is irrelevant)
//   state_i        : current state of this cell, 1 = alive
//   birth_mask_i   : bit n = dead cell with n live neighbours is born
//   survive_mask_i : bit n = live cell with n live neighbours survives
//   next_o         : state after one generation
module bsg_cgol_rule_cell
  import bsg_cgol_pkg::*;
(
  input  logic [7:0] nbr_i,
  input  logic       state_i,
  input  logic [8:0] birth_mask_i,
  input  logic [8:0] survive_mask_i,
  output logic       next_o
);

  logic [3:0] cnt;
  logic [8:0] rule_mask;
  logic [8:0] rule_shift;

  bsg_popcount #(.width_p(8)) u_cnt (
    .a_i (nbr_i),
    .o   (cnt)
  );

  // cnt never exceeds 8, so a shift-and-take-LSB selects the mask bit
  // without an out-of-range index.
  assign rule_mask  = state_i ? survive_mask_i : birth_mask_i;
  assign rule_shift = rule_mask >> cnt;
  assign next_o     = rule_shift[0];

endmodule

// File: rtl/bsg_popcount.sv
// Combinational population count.
//   a_i : width_p-bit input vector
//   o   : number of set bits in a_i, $clog2(width_p+1) bits wide
module bsg_popcount #(
  parameter int width_p = 8
) (
  input  logic [width_p-1:0]         a_i,
  output logic [$clog2(width_p+1)-1:0] o
);

  localparam int cnt_w = $clog2(width_p + 1);

  always_comb begin
    o = '0;
    for (int i = 0; i < width_p; i++) begin
      o = o + {{(cnt_w-1){1'b0}}, a_i[i]};
    end
  end

endmodule

// File: rtl/bsg_cgol_row.sv
// One row of width_p Life-like cells stepping in lockstep.
//   clk_i          : clock
//   reset_n_i      : asynchronous active-low reset
//   en_i           : step every cell one generation (has priority over update_i)
//   north_i        : row above, bit k sits above cell k
//   south_i        : row below
//   update_i       : parallel load of update_row_i when en_i=0
//   update_row_i   : load value
//   birth_mask_i   : birth rule, bit n = born with n neighbours
//   survive_mask_i : survival rule, bit n = survives with n neighbours
//   row_o          : registered cell states
//   pop_o          : live cells in row_o
//   gen_o          : generations stepped since reset or load
//   stable_o       : last step left the row unchanged
module bsg_cgol_row
  import bsg_cgol_pkg::*;
#(
  parameter int width_p     = 16,
  parameter int wrap_p      = 1,
  parameter int gen_width_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         en_i,
  input  logic [width_p-1:0]           north_i,
  input  logic [width_p-1:0]           south_i,
  input  logic                         update_i,
  input  logic [width_p-1:0]           update_row_i,
  input  logic [8:0]                   birth_mask_i,
  input  logic [8:0]                   survive_mask_i,
  output logic [width_p-1:0]           row_o,
  output logic [$clog2(width_p+1)-1:0] pop_o,
  output logic [gen_width_p-1:0]       gen_o,
  output logic                         stable_o
);

  localparam int pop_w = $clog2(width_p + 1);

  // With fewer than three cells, west and east neighbours alias.
  if (width_p < 3) begin : g_width_chk
    $error("bsg_cgol_row: width_p must be >= 3");
  end

  logic [width_p-1:0]     row_p1;
  logic [pop_w-1:0]       pop_p1;
  logic [gen_width_p-1:0] gen_p1;
  logic                   stable_p1;

  logic [width_p-1:0]     row_step_p0;
  logic [width_p-1:0]     row_nxt_p0;
  logic [pop_w-1:0]       pop_nxt_p0;

  // ---- stage p0: combinational next generation ----
  for (genvar k = 0; k < width_p; k++) begin : g_cell
    localparam int wi = bsg_cgol_wrap_idx(k - 1, width_p);
    localparam int ei = bsg_cgol_wrap_idx(k + 1, width_p);

    logic w_row, e_row, w_n, e_n, w_s, e_s;

    if (wrap_p != 0 || k > 0) begin : g_w
      assign w_row = row_p1[wi];
      assign w_n   = north_i[wi];
      assign w_s   = south_i[wi];
    end else begin : g_w_dead
      assign w_row = 1'b0;
      assign w_n   = 1'b0;
      assign w_s   = 1'b0;
    end

    if (wrap_p != 0 || k < width_p - 1) begin : g_e
      assign e_row = row_p1[ei];
      assign e_n   = north_i[ei];
      assign e_s   = south_i[ei];
    end else begin : g_e_dead
      assign e_row = 1'b0;
      assign e_n   = 1'b0;
      assign e_s   = 1'b0;
    end

    bsg_cgol_rule_cell u_rule (
      .nbr_i          ({w_row, e_row, w_n, north_i[k], e_n, w_s, south_i[k], e_s}),
      .state_i        (row_p1[k]),
      .birth_mask_i   (birth_mask_i),
      .survive_mask_i (survive_mask_i),
      .next_o         (row_step_p0[k])
    );
  end

  // Population is counted on whatever is about to be registered so that
  // pop_o lines up with row_o in the same cycle.
  assign row_nxt_p0 = en_i ? row_step_p0 : update_row_i;

  bsg_popcount #(.width_p(width_p)) u_pop (
    .a_i (row_nxt_p0),
    .o   (pop_nxt_p0)
  );

  // ---- stage p1: registered row state ----
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      row_p1    <= '0;
      pop_p1    <= '0;
      gen_p1    <= '0;
      stable_p1 <= 1'b0;
    end else if (en_i) begin
      row_p1    <= row_nxt_p0;
      pop_p1    <= pop_nxt_p0;
      gen_p1    <= gen_p1 + {{(gen_width_p-1){1'b0}}, 1'b1};
      stable_p1 <= (row_step_p0 == row_p1);
    end else if (update_i) begin
      row_p1    <= row_nxt_p0;
      pop_p1    <= pop_nxt_p0;
      gen_p1    <= '0;
      stable_p1 <= 1'b0;
    end
  end

  assign row_o    = row_p1;
  assign pop_o    = pop_p1;
  assign gen_o    = gen_p1;
  assign stable_o = stable_p1;

endmodule

// File: tb/tb_bsg_cgol_row.sv
module tb_bsg_cgol_row;
  import bsg_cgol_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       update = 1'b0;
  logic [7:0] north = '0;
  logic [7:0] south = '0;
  logic [7:0] update_row = '0;
  logic [8:0] birth = bsg_cgol_birth_conway;
  logic [8:0] survive = bsg_cgol_survive_conway;

  logic [7:0]  w_row, d_row;
  logic [3:0]  w_pop, d_pop;
  logic [15:0] w_gen;
  logic [1:0]  d_gen;
  logic        w_stable, d_stable;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bsg_cgol_row #(.width_p(8), .wrap_p(1), .gen_width_p(16)) u_wrap (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .north_i(north), .south_i(south),
    .update_i(update), .update_row_i(update_row), .birth_mask_i(birth),
    .survive_mask_i(survive), .row_o(w_row), .pop_o(w_pop), .gen_o(w_gen),
    .stable_o(w_stable)
  );

  bsg_cgol_row #(.width_p(8), .wrap_p(0), .gen_width_p(2)) u_dead (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .north_i(north), .south_i(south),
    .update_i(update), .update_row_i(update_row), .birth_mask_i(birth),
    .survive_mask_i(survive), .row_o(d_row), .pop_o(d_pop), .gen_o(d_gen),
    .stable_o(d_stable)
  );

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    update = 1'b1;
    update_row = v;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic test_reset();
    load(8'hFF);
    checks++;
    if (w_pop !== 4'd8) begin
      errors++; $display("FAIL reset_pre_pop: got %0d want 8", w_pop);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (w_row !== 8'h00 || w_pop !== 4'd0 || w_gen !== 16'd0 || w_stable !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: row=%h pop=%0d gen=%0d stable=%b want 00/0/0/0",
               w_row, w_pop, w_gen, w_stable);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_blinker();
    birth = bsg_cgol_birth_conway;
    survive = bsg_cgol_survive_conway;
    north = '0;
    south = '0;
    load(8'b0001_1100);
    step();
    checks++;
    if (w_row !== 8'b0000_1000 || w_pop !== 4'd1 || w_gen !== 16'd1 || w_stable !== 1'b0) begin
      errors++;
      $display("FAIL blinker_wrap: row=%b pop=%0d gen=%0d stable=%b want 00001000/1/1/0",
               w_row, w_pop, w_gen, w_stable);
    end
    checks++;
    if (d_row !== 8'b0000_1000 || d_pop !== 4'd1) begin
      errors++;
      $display("FAIL blinker_dead: row=%b pop=%0d want 00001000/1", d_row, d_pop);
    end
    // masks changed while idle must not disturb the row
    @(negedge clk);
    birth = '0;
    survive = '0;
    @(posedge clk);
    #1;
    checks++;
    if (w_row !== 8'b0000_1000 || w_gen !== 16'd1) begin
      errors++;
      $display("FAIL idle_hold: row=%b gen=%0d want 00001000/1", w_row, w_gen);
    end
    // all-zero masks kill everything on a step
    step();
    checks++;
    if (w_row !== 8'h00 || w_pop !== 4'd0 || w_gen !== 16'd2) begin
      errors++;
      $display("FAIL zero_masks: row=%b pop=%0d gen=%0d want 00000000/0/2", w_row, w_pop, w_gen);
    end
    birth = bsg_cgol_birth_conway;
    survive = bsg_cgol_survive_conway;
  endtask

  task automatic test_wrap_edges();
    north = 8'b0000_0001;
    south = '0;
    load(8'b1000_0010);
    step();
    checks++;
    if (w_row !== 8'b0000_0001) begin
      errors++; $display("FAIL wrap_edge: row=%b want 00000001", w_row);
    end
    checks++;
    if (d_row !== 8'b0000_0000) begin
      errors++; $display("FAIL dead_edge: row=%b want 00000000", d_row);
    end
    north = '0;
  endtask

  task automatic test_rule_switch();
    north = 8'b0000_0111;
    south = 8'b0000_0111;
    load(8'h00);
    step();
    checks++;
    if (w_row !== 8'b0000_0000) begin
      errors++; $display("FAIL rule_conway: row=%b want 00000000", w_row);
    end
    birth = bsg_cgol_birth_highlife;
    load(8'h00);
    step();
    checks++;
    if (w_row !== 8'b0000_0010 || w_pop !== 4'd1) begin
      errors++; $display("FAIL rule_highlife_wrap: row=%b pop=%0d want 00000010/1", w_row, w_pop);
    end
    checks++;
    if (d_row !== 8'b0000_0010) begin
      errors++; $display("FAIL rule_highlife_dead: row=%b want 00000010", d_row);
    end
    birth = bsg_cgol_birth_conway;
    north = '0;
    south = '0;
  endtask

  task automatic test_stability();
    load(8'h00);
    step();
    step();
    step();
    checks++;
    if (w_row !== 8'h00 || w_stable !== 1'b1 || w_gen !== 16'd3) begin
      errors++;
      $display("FAIL stable: row=%b stable=%b gen=%0d want 00000000/1/3", w_row, w_stable, w_gen);
    end
    step();
    checks++;
    if (d_gen !== 2'd0 || w_gen !== 16'd4) begin
      errors++; $display("FAIL gen_wrap: dead_gen=%0d wrap_gen=%0d want 0/4", d_gen, w_gen);
    end
    load(8'h01);
    checks++;
    if (w_gen !== 16'd0 || w_stable !== 1'b0 || w_pop !== 4'd1 || w_row !== 8'h01) begin
      errors++;
      $display("FAIL load_clear: gen=%0d stable=%b pop=%0d row=%b want 0/0/1/00000001",
               w_gen, w_stable, w_pop, w_row);
    end
  endtask

  task automatic test_back_to_back();
    load(8'b0001_1100);
    @(negedge clk);
    en = 1'b1;
    update = 1'b1;
    update_row = 8'hFF;
    @(posedge clk);
    #1;
    en = 1'b0;
    update = 1'b0;
    checks++;
    if (w_row !== 8'b0000_1000 || w_gen !== 16'd1 || w_pop !== 4'd1) begin
      errors++;
      $display("FAIL en_over_update: row=%b gen=%0d pop=%0d want 00001000/1/1", w_row, w_gen, w_pop);
    end
    // second step turns the blinker back to horizontal-equivalent row of one cell dying
    step();
    checks++;
    if (w_row !== 8'h00 || w_gen !== 16'd2 || w_stable !== 1'b0) begin
      errors++;
      $display("FAIL lone_cell: row=%b gen=%0d stable=%b want 00000000/2/0", w_row, w_gen, w_stable);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_blinker();
    test_wrap_edges();
    test_rule_switch();
    test_stability();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_cgol_row.md
Name: bsg_cgol_row

Overview:
- Parametrised successor to the single Game-of-Life cell: one row of width_p Life-like cells that all update together.
- Birth and survival rules are runtime-programmable masks (B/S notation), so the row is not fixed to Conway B3/S23.
- Row edges are either toroidal (wrap) or dead.
- North and south neighbour rows come from adjacent row instances, so a full grid is a vertical stack of these blocks.
- The block also keeps a generation counter, a registered population count and a stability flag, for the array controller.

Parameters:
- width_p, 16, number of cells in the row (>= 3).
- wrap_p, 1, 1 = west/east edges wrap toroidally; 0 = cells outside the row are dead.
- gen_width_p, 16, width of the generation counter.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  advance every cell one generation this cycle.
- north_i  in  width_p  current state of the row above; bit k is above cell k.
- south_i  in  width_p  current state of the row below.
- update_i  in  1  parallel-load the row (ignored when en_i=1).
- update_row_i  in  width_p  load value.
- birth_mask_i  in  9  bit n=1 means a dead cell with n live neighbours is born.
- survive_mask_i  in  9  bit n=1 means a live cell with n live neighbours survives.
- row_o  out  width_p  registered cell states; 1 = alive.
- pop_o  out  $clog2(width_p+1)  number of live cells in row_o.
- gen_o  out  gen_width_p  count of generations stepped since the last reset or load.
- stable_o  out  1  the last step left the row unchanged.

Behaviour:
- Reset is asynchronous, active-low and takes effect immediately on assertion. It clears row_o, pop_o, gen_o and stable_o to 0.
- Release of reset is synchronous to clk_i. Asserting reset mid-run aborts the run; no partial step is committed.
- Neighbour count for cell k covers:
  - row bits k-1 and k+1;
  - north_i and south_i bits k-1, k and k+1.
  - The count is always 0..8.
- Edge handling:
  - wrap_p=1: index -1 maps to width_p-1 and index width_p maps to 0, in all three rows.
  - wrap_p=0: out-of-range neighbours read as 0.
- Next state of cell k with neighbour count n:
  - alive cell: survive_mask_i[n];
  - dead cell: birth_mask_i[n].
- Masks are sampled in the cycle en_i is high. Changing them while idle has no effect.
- Per-cycle priority:
  - en_i=1: the whole row steps. gen_o increments, wrapping modulo 2^gen_width_p. stable_o is set to (next row == current row). update_i is ignored.
  - en_i=0, update_i=1: row_o loads update_row_i. gen_o is cleared to 0 and stable_o is cleared to 0.
  - otherwise: all state holds.
- Latency: one cycle.
  - row_o shows the new value on the clock edge after en_i or update_i.
  - pop_o is registered from the next-state row, so it is always consistent with row_o in the same cycle (no extra latency).
- All cells step in lockstep off the same north_i/south_i snapshot. The array controller must drive north_i/south_i from neighbour rows' row_o, which are registered, so there is no combinational loop.
- With width_p=3 and wrap_p=1, cell k-1 and cell k+1 are distinct cells. The corresponding neighbour term is counted twice only if the indices coincide. That cannot happen for width_p >= 3, so width_p < 3 is illegal (elaboration assert).
- All-zero masks make every cell die on each step.
- Masks with bit n set for n > 8 are not possible: the masks are 9 bits wide, covering counts 0..8.

Decomposition:
- Package bsg_cgol_pkg:
  - localparams bsg_cgol_birth_conway = 9'b0_0000_1000 (B3) and bsg_cgol_survive_conway = 9'b0_0000_1100 (S23);
  - highlife constant birth = 9'b0_0100_1000 (B36);
  - a function for neighbour index wrap.
- Sub-module bsg_cgol_rule_cell: combinational next-state for one cell.
  - Inputs: 8 neighbours, current state, both masks.
  - Uses bsg_popcount #(8) for the neighbour count.
  - Instantiated width_p times via generate.
- A second bsg_popcount #(width_p) computes the population.

Test Plan:
- Reset: drive reset_n_i=0 between clock edges with row_o=8'hFF -> row_o, pop_o, gen_o and stable_o all read 0 before the next edge.
- Blinker, width_p=8, Conway masks, north/south=0: load 8'b0001_1100, pulse en_i -> row_o=8'b0000_1000, pop_o=1, gen_o=1, stable_o=0.
- Wrap versus dead edges, width_p=8: load 8'b1000_0010, north_i=8'b0000_0001, south_i=0, en_i -> wrap_p=1 gives row_o=8'b0000_0001; wrap_p=0 gives row_o=8'b0000_0000.
- Rule switch, width_p=8: load 8'b0000_0000, north_i=8'b0000_0111, south_i=8'b0000_0111 (cell 1 sees 6), en_i:
  - Conway masks -> row_o=8'b0000_0000 (bits 0 and 2 see 4, bit 3 sees 2);
  - HighLife masks -> row_o=8'b0000_0010.
- Stability: load 8'b0000_0000, pulse en_i three times -> row_o=0, stable_o=1, gen_o=3; then update_i with 8'h01 -> gen_o=0, stable_o=0, pop_o=1.
- Simultaneous en_i=1 and update_i=1 with update_row_i=8'hFF on blinker 8'b0001_1100 -> step wins: row_o=8'b0000_1000, gen_o increments.
